// File: rtl/idu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | idu_pkg : opcodes, alu_op encoding, FSM states, decoded bundle     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package idu_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_BR    = 4'd1,
    ALU_R     = 4'd2,
    ALU_I     = 4'd3,
    ALU_LUI   = 4'd4,
    ALU_JAL   = 4'd5,
    ALU_JALR  = 4'd6,
    ALU_AUIPC = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // XLEN-wide fields (pc, imm) live beside this struct so the package stays width-agnostic
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;
    alu_op_e    alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       word;
    logic       illegal;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/idu_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | idu_decode : combinational RV32/RV64 base-integer decoder          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module idu_decode
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  localparam bit RV64 = (XLEN == 64);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    ctrl = '0;
    imm  = '0;
    if (inst[1:0] != 2'b11) begin
      ctrl.illegal = 1'b1;
    end else begin
      unique case (inst[6:0])
        // inst[3] separates the *-32 word forms from their XLEN-wide twins
        OPC_OP, OPC_OP_32: begin
          if (inst[3] && !RV64) begin
            ctrl.illegal = 1'b1;
          end else begin
            ctrl.rs1       = inst[19:15];
            ctrl.rs2       = inst[24:20];
            ctrl.rd        = inst[11:7];
            ctrl.funct3    = inst[14:12];
            ctrl.funct7    = inst[31:25];
            ctrl.alu_op    = ALU_R;
            ctrl.reg_write = 1'b1;
            ctrl.word      = inst[3];
          end
        end
        OPC_OP_IMM, OPC_OP_IMM_32: begin
          if (inst[3] && !RV64) begin
            ctrl.illegal = 1'b1;
          end else begin
            ctrl.rs1       = inst[19:15];
            ctrl.rd        = inst[11:7];
            ctrl.funct3    = inst[14:12];
            ctrl.funct7    = inst[31:25];
            ctrl.alu_op    = ALU_I;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.word      = inst[3];
            imm            = imm_i;
          end
        end
        OPC_LOAD: begin
          ctrl.rs1        = inst[19:15];
          ctrl.rd         = inst[11:7];
          ctrl.funct3     = inst[14:12];
          ctrl.alu_op     = ALU_ADD;
          ctrl.alu_src    = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          imm             = imm_i;
        end
        OPC_STORE: begin
          ctrl.rs1       = inst[19:15];
          ctrl.rs2       = inst[24:20];
          ctrl.funct3    = inst[14:12];
          ctrl.alu_op    = ALU_ADD;
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          imm            = imm_s;
        end
        OPC_BRANCH: begin
          ctrl.rs1    = inst[19:15];
          ctrl.rs2    = inst[24:20];
          ctrl.funct3 = inst[14:12];
          ctrl.alu_op = ALU_BR;
          ctrl.branch = 1'b1;
          imm         = imm_b;
        end
        OPC_LUI: begin
          ctrl.rd        = inst[11:7];
          ctrl.alu_op    = ALU_LUI;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          imm            = imm_u;
        end
        OPC_AUIPC: begin
          ctrl.rd        = inst[11:7];
          ctrl.alu_op    = ALU_AUIPC;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          imm            = imm_u;
        end
        OPC_JAL: begin
          ctrl.rd        = inst[11:7];
          ctrl.alu_op    = ALU_JAL;
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          imm            = imm_j;
        end
        OPC_JALR: begin
          ctrl.rs1       = inst[19:15];
          ctrl.rd        = inst[11:7];
          ctrl.funct3    = inst[14:12];
          ctrl.alu_op    = ALU_JALR;
          ctrl.alu_src   = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          imm            = imm_i;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/idu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | idu_pipe : decode stage with a two-entry skid buffer and           |
// |            saturating illegal-instruction counter  -- rev 1.0      |
// +--------------------------------------------------------------------+
module idu_pipe
  import idu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_alu_src,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_reg_write,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_word,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  idu_decode #(.XLEN(XLEN)) u_decode (
    .inst (in_inst),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  state_e          state_q,     state_d;
  logic            in_ready_q,  in_ready_d;
  ctrl_t           main_ctrl_q, main_ctrl_d;
  logic [XLEN-1:0] main_pc_q,   main_pc_d;
  logic [XLEN-1:0] main_imm_q,  main_imm_d;
  ctrl_t           skid_ctrl_q, skid_ctrl_d;
  logic [XLEN-1:0] skid_pc_q,   skid_pc_d;
  logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic accept;
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_pc_d   = main_pc_q;
    main_imm_d  = main_imm_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_pc_d   = skid_pc_q;
    skid_imm_d  = skid_imm_q;
    cnt_d       = cnt_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      if (accept && dec_ctrl.illegal && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_MAIN;
            main_ctrl_d = dec_ctrl;
            main_pc_d   = in_pc;
            main_imm_d  = dec_imm;
          end
        end
        ST_MAIN: begin
          if (accept && out_ready) begin
            main_ctrl_d = dec_ctrl;
            main_pc_d   = in_pc;
            main_imm_d  = dec_imm;
          end else if (accept) begin
            state_d     = ST_SKID;
            skid_ctrl_d = dec_ctrl;
            skid_pc_d   = in_pc;
            skid_imm_d  = dec_imm;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state_d     = ST_MAIN;
            main_ctrl_d = skid_ctrl_q;
            main_pc_d   = skid_pc_q;
            main_imm_d  = skid_imm_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_pc_q   <= '0;
      main_imm_q  <= '0;
      skid_ctrl_q <= '0;
      skid_pc_q   <= '0;
      skid_imm_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_pc_q   <= main_pc_d;
      main_imm_q  <= main_imm_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_pc_q   <= skid_pc_d;
      skid_imm_q  <= skid_imm_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != ST_EMPTY);
  assign out_pc         = main_pc_q;
  assign out_imm        = main_imm_q;
  assign out_rs1        = main_ctrl_q.rs1;
  assign out_rs2        = main_ctrl_q.rs2;
  assign out_rd         = main_ctrl_q.rd;
  assign out_funct3     = main_ctrl_q.funct3;
  assign out_funct7     = main_ctrl_q.funct7;
  assign out_alu_op     = main_ctrl_q.alu_op;
  assign out_alu_src    = main_ctrl_q.alu_src;
  assign out_mem_read   = main_ctrl_q.mem_read;
  assign out_mem_write  = main_ctrl_q.mem_write;
  assign out_mem_to_reg = main_ctrl_q.mem_to_reg;
  assign out_reg_write  = main_ctrl_q.reg_write;
  assign out_branch     = main_ctrl_q.branch;
  assign out_jump       = main_ctrl_q.jump;
  assign out_word       = main_ctrl_q.word;
  assign out_illegal    = main_ctrl_q.illegal;
  assign illegal_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_idu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_idu_pipe : directed bench, three configurations share stimulus  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_idu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: XLEN=32, b: XLEN=64, c: XLEN=32 with a 2-bit counter
  logic        a_in_ready, a_out_valid, a_alu_src, a_mem_read, a_mem_write, a_mem_to_reg;
  logic        a_reg_write, a_branch, a_jump, a_word, a_illegal;
  logic [31:0] a_pc, a_imm, a_cnt;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7;
  logic [3:0]  a_alu_op;

  logic        b_in_ready, b_out_valid, b_alu_src, b_mem_read, b_mem_write, b_mem_to_reg;
  logic        b_reg_write, b_branch, b_jump, b_word, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [31:0] b_cnt;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7;
  logic [3:0]  b_alu_op;

  logic        c_in_ready, c_out_valid, c_alu_src, c_mem_read, c_mem_write, c_mem_to_reg;
  logic        c_reg_write, c_branch, c_jump, c_word, c_illegal;
  logic [31:0] c_pc, c_imm;
  logic [1:0]  c_cnt;
  logic [4:0]  c_rs1, c_rs2, c_rd;
  logic [2:0]  c_f3;
  logic [6:0]  c_f7;
  logic [3:0]  c_alu_op;

  idu_pipe #(.XLEN(32), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_funct3(a_f3),
    .out_funct7(a_f7), .out_imm(a_imm), .out_alu_op(a_alu_op), .out_alu_src(a_alu_src),
    .out_mem_read(a_mem_read), .out_mem_write(a_mem_write), .out_mem_to_reg(a_mem_to_reg),
    .out_reg_write(a_reg_write), .out_branch(a_branch), .out_jump(a_jump), .out_word(a_word),
    .out_illegal(a_illegal), .illegal_cnt(a_cnt)
  );

  idu_pipe #(.XLEN(64), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_funct3(b_f3),
    .out_funct7(b_f7), .out_imm(b_imm), .out_alu_op(b_alu_op), .out_alu_src(b_alu_src),
    .out_mem_read(b_mem_read), .out_mem_write(b_mem_write), .out_mem_to_reg(b_mem_to_reg),
    .out_reg_write(b_reg_write), .out_branch(b_branch), .out_jump(b_jump), .out_word(b_word),
    .out_illegal(b_illegal), .illegal_cnt(b_cnt)
  );

  idu_pipe #(.XLEN(32), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_inst(in_inst),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_pc(c_pc), .out_rs1(c_rs1), .out_rs2(c_rs2), .out_rd(c_rd), .out_funct3(c_f3),
    .out_funct7(c_f7), .out_imm(c_imm), .out_alu_op(c_alu_op), .out_alu_src(c_alu_src),
    .out_mem_read(c_mem_read), .out_mem_write(c_mem_write), .out_mem_to_reg(c_mem_to_reg),
    .out_reg_write(c_reg_write), .out_branch(c_branch), .out_jump(c_jump), .out_word(c_word),
    .out_illegal(c_illegal), .illegal_cnt(c_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_in_ready", a_in_ready, 1);
    check_eq("rst_cnt", a_cnt, 0);
    check_eq("rst_pc", a_pc, 0);
    check_eq("rst_imm64", b_imm, 0);
    check_eq("rst_cnt_c", c_cnt, 0);
    rst = 1'b0;
    step();

    // addi x1,x0,5
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h100;
    step();
    in_valid = 1'b0;
    check_eq("addi_valid", a_out_valid, 1);
    check_eq("addi_rd", a_rd, 1);
    check_eq("addi_rs1", a_rs1, 0);
    check_eq("addi_imm", a_imm, 5);
    check_eq("addi_alu_op", a_alu_op, 3);
    check_eq("addi_alu_src", a_alu_src, 1);
    check_eq("addi_reg_write", a_reg_write, 1);
    check_eq("addi_pc", a_pc, 64'h100);
    check_eq("addi_illegal", a_illegal, 0);
    step();
    check_eq("drain_empty", a_out_valid, 0);

    // addi x2,x0,-1 : sign extension on both widths
    in_valid = 1'b1; in_inst = 32'hFFF00113; in_pc = 64'h8000_0000_0000_0004;
    step();
    check_eq("neg_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("neg_rd64", b_rd, 2);
    check_eq("neg_imm32", a_imm, 64'hFFFF_FFFF);
    check_eq("pc64", b_pc, 64'h8000_0000_0000_0004);

    // addiw x1,x0,1 : word op on RV64, illegal on RV32
    in_inst = 32'h0010009B;
    step();
    check_eq("addiw_word64", b_word, 1);
    check_eq("addiw_legal64", b_illegal, 0);
    check_eq("addiw_alu_op64", b_alu_op, 3);
    check_eq("addiw_imm64", b_imm, 1);
    check_eq("addiw_illegal32", a_illegal, 1);
    check_eq("addiw_alu_op32", a_alu_op, 0);
    check_eq("addiw_imm32", a_imm, 0);
    check_eq("addiw_reg_write32", a_reg_write, 0);
    check_eq("addiw_cnt32", a_cnt, 1);
    check_eq("addiw_cnt_c", c_cnt, 1);
    check_eq("addiw_cnt64", b_cnt, 0);

    // sw x1,-4(x2)
    in_inst = 32'hFE112E23;
    step();
    check_eq("sw_mem_write", a_mem_write, 1);
    check_eq("sw_rs1", a_rs1, 2);
    check_eq("sw_rs2", a_rs2, 1);
    check_eq("sw_rd", a_rd, 0);
    check_eq("sw_imm", a_imm, 64'hFFFF_FFFC);
    check_eq("sw_reg_write", a_reg_write, 0);
    check_eq("sw_funct3", a_f3, 2);

    // beq x0,x0,-8
    in_inst = 32'hFE000CE3;
    step();
    check_eq("beq_branch", a_branch, 1);
    check_eq("beq_alu_op", a_alu_op, 1);
    check_eq("beq_imm", a_imm, 64'hFFFF_FFF8);

    // jal x1,-4
    in_inst = 32'hFFDFF0EF;
    step();
    check_eq("jal_jump", a_jump, 1);
    check_eq("jal_alu_op", a_alu_op, 5);
    check_eq("jal_rd", a_rd, 1);
    check_eq("jal_imm", a_imm, 64'hFFFF_FFFC);

    // lui x5,0x80000
    in_inst = 32'h800002B7;
    step();
    check_eq("lui_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui_alu_op", b_alu_op, 4);
    check_eq("lui_rd", b_rd, 5);

    // inst[1:0] != 2'b11
    in_inst = 32'h0000_0000;
    step();
    check_eq("zero_illegal32", a_illegal, 1);
    check_eq("zero_illegal64", b_illegal, 1);
    check_eq("zero_cnt32", a_cnt, 2);
    check_eq("zero_cnt_c", c_cnt, 2);
    check_eq("zero_cnt64", b_cnt, 1);
    in_valid = 1'b0;
    step();
    check_eq("idle_valid", a_out_valid, 0);

    // back-to-back into a stalled consumer, then release
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h200;
    step();
    check_eq("b2b_ready1", a_in_ready, 1);
    check_eq("b2b_valid1", a_out_valid, 1);
    in_inst = 32'h00200113; in_pc = 64'h204;
    step();
    check_eq("b2b_ready2", a_in_ready, 0);
    check_eq("b2b_rd_hold", a_rd, 1);
    in_inst = 32'h00300193; in_pc = 64'h208;
    step();
    check_eq("b2b_ready3", a_in_ready, 0);
    check_eq("b2b_stall_rd", a_rd, 1);
    check_eq("b2b_stall_pc", a_pc, 64'h200);
    out_ready = 1'b1;
    step();
    check_eq("b2b_out2_rd", a_rd, 2);
    check_eq("b2b_out2_pc", a_pc, 64'h204);
    check_eq("b2b_ready_back", a_in_ready, 1);
    step();
    check_eq("b2b_out3_rd", a_rd, 3);
    check_eq("b2b_out3_pc", a_pc, 64'h208);
    check_eq("b2b_out3_imm", a_imm, 3);
    in_valid = 1'b0;
    step();
    check_eq("b2b_no_dup", a_out_valid, 0);

    // flush while in SKID, with drain requested
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h300;
    step();
    in_inst = 32'h00200113; in_pc = 64'h304;
    step();
    in_valid = 1'b0;
    check_eq("skid_reached", a_in_ready, 0);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_valid", a_out_valid, 0);
    check_eq("flush_ready", a_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("flush_no_emit", a_out_valid, 0);
    end

    // acceptance coinciding with flush is discarded and not counted
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFFF_FFFF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_acc_valid", a_out_valid, 0);
    check_eq("flush_acc_cnt", a_cnt, 2);
    check_eq("flush_acc_cnt_c", c_cnt, 2);

    // counter saturation
    in_valid = 1'b1; in_inst = 32'hFFFF_FFFF;
    repeat (5) step();
    in_valid = 1'b0;
    check_eq("sat_cnt_c", c_cnt, 3);
    check_eq("sat_cnt32", a_cnt, 7);
    check_eq("sat_cnt64", b_cnt, 6);
    check_eq("sat_illegal", a_illegal, 1);
    step();

    // asynchronous reset while holding two entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h400;
    step();
    in_inst = 32'h00200113; in_pc = 64'h404;
    step();
    in_valid = 1'b0;
    check_eq("pre_rst_skid", a_in_ready, 0);
    check_eq("pre_rst_valid", a_out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", a_out_valid, 0);
    check_eq("arst_ready", a_in_ready, 1);
    check_eq("arst_cnt", a_cnt, 0);
    check_eq("arst_cnt_c", c_cnt, 0);
    check_eq("arst_pc", a_pc, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("post_rst_valid", a_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
